dmem_ctrl: RTL and testbench

Data-memory access controller for the M stage of the five-stage MIPS pipeline; consumes the M-stage address/store data and returns load data to the M/W pipeline register. It converts one load or store into a request/acknowledge bus transaction, generates byte lanes, sign/zero-extends loads, and stalls the pipeline until the transaction completes. A bus timeout guard prevents a dead slave from hanging the core.

---
 rtl/dmem_ctrl_pkg.sv | 34 +++
 rtl/dmem_ctrl_if.sv | 21 ++
 rtl/dmem_ctrl_load_ext.sv | 36 +++
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory controller: access-size
// encodings, FSM states, timeout default and byte-lane helpers.
package dmem_ctrl_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmemState_t;

  // Little-endian lane enables; size 2'b11 behaves as a word.
  function automatic logic [3:0] laneEnables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_BYTE: return 4'b0001 << lo;
      MEM_HALF: return 4'b0011 << {lo[1], 1'b0};
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      MEM_BYTE: return {4{wd[7:0]}};
      MEM_HALF: return {2{wd[15:0]}};
      default:  return wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/acknowledge data-bus bundle between the M-stage controller
// (master) and a memory or peripheral slave.
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl_load_ext.sv
// Load-data lane select and sign/zero extension; purely combinational so an
// instruction-side unit can reuse it unchanged.
module dmem_ctrl_load_ext
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] ext
);

  logic signed [7:0]  byteSel;
  logic signed [15:0] halfSel;
  logic signed [31:0] byteSx;
  logic signed [31:0] halfSx;

  always_comb begin
    case (lane)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    halfSel = lane[1] ? rdata[31:16] : rdata[15:0];
    byteSx  = byteSel;
    halfSx  = halfSel;

    case (size)
      MEM_BYTE: ext = sign ? byteSx : {24'b0, byteSel};
      MEM_HALF: ext = sign ? halfSx : {16'b0, halfSel};
      default:  ext = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: one load/store becomes one bus transaction
// with a timeout guard. Define DMEM_ALIGN_CHECK_EN to trap misaligned accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic        memsignM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        buserrM,
  output logic        adelM,
  output logic        adesM,
  dmem_ctrl_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  dmemState_t  state, stateNext;
  logic [7:0]  waitCnt;
  logic [1:0]  addrLoL, sizeL;
  logic        signL, weL;
  logic [1:0]  addrLoEff;
  logic        alignFault;
  logic        start, ackHit, toHit;
  logic [31:0] loadData;

`ifdef DMEM_ALIGN_CHECK_EN
  assign alignFault = ((memsizeM == MEM_HALF) && aluoutM[0]) ||
                      (memsizeM[1] && (aluoutM[1:0] != 2'b00));
  assign addrLoEff  = aluoutM[1:0];
`else
  // Without trapping, misaligned addresses snap down to the natural boundary.
  assign alignFault = 1'b0;
  assign addrLoEff  = (memsizeM == MEM_BYTE) ? aluoutM[1:0] :
                      (memsizeM == MEM_HALF) ? {aluoutM[1], 1'b0} : 2'b00;
`endif

  dmem_ctrl_load_ext loadExt (
    .rdata (bus.bus_rdata),
    .lane  (addrLoL),
    .size  (sizeL),
    .sign  (signL),
    .ext   (loadData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)           stateNext = WAIT;
      WAIT:    if (ackHit || toHit) stateNext = DONE;
      default:                      stateNext = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    ackHit = 1'b0;
    toHit  = 1'b0;
    stallM = 1'b0;
    adelM  = 1'b0;
    adesM  = 1'b0;
    case (state)
      IDLE: begin
        start  = memenM && !alignFault;
        stallM = start;
        adelM  = memenM && alignFault && !memwriteM;
        adesM  = memenM && alignFault && memwriteM;
      end
      WAIT: begin
        stallM = 1'b1;
        ackHit = bus.bus_ack;
        toHit  = !bus.bus_ack && (waitCnt == TIMEOUT_CNT);
      end
      default: ;
    endcase
  end

  // Issue: register bus outputs and access attributes; WAIT: count and complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      readdataM     <= '0;
      buserrM       <= 1'b0;
      waitCnt       <= '0;
      addrLoL       <= '0;
      sizeL         <= '0;
      signL         <= 1'b0;
      weL           <= 1'b0;
    end else begin
      buserrM <= toHit;
      if (start) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= memwriteM;
        bus.bus_addr  <= {aluoutM[31:2], 2'b00};
        bus.bus_be    <= laneEnables(memsizeM, addrLoEff);
        bus.bus_wdata <= laneData(memsizeM, writedataM);
        waitCnt       <= '0;
        addrLoL       <= addrLoEff;
        sizeL         <= memsizeM;
        signL         <= memsignM;
        weL           <= memwriteM;
      end else if (state == WAIT) begin
        if (ackHit || toHit) bus.bus_req <= 1'b0;
        else                 waitCnt     <= waitCnt + 8'd1;
      end
      if (ackHit && !weL) readdataM <= loadData;
      else if (toHit)     readdataM <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed accesses queue their expected bus
// request and completion; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, memsignM;
  logic [1:0]  memsizeM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, buserrM, adelM, adesM;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .memsizeM   (memsizeM),
    .memsignM   (memsignM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .buserrM    (buserrM),
    .adelM      (adelM),
    .adesM      (adesM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } cpl_t;

  req_t reqQ[$];
  cpl_t cplQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares each new bus request and each stall release.
  initial begin : monitor
    logic prevReq, prevStall, prevErr;
    int   stallCnt;
    req_t r;
    cpl_t c;
    prevReq = 1'b0; prevStall = 1'b0; prevErr = 1'b0; stallCnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevReq = 1'b0; prevStall = 1'b0; prevErr = 1'b0; stallCnt = 0;
      end else begin
        if (bus.bus_req && !prevReq) begin
          if (reqQ.size() == 0) begin
            chk("unexpected_req", bus.bus_addr, 32'hFFFF_FFFF);
          end else begin
            r = reqQ.pop_front();
            chk("bus_addr",  bus.bus_addr,  r.addr);
            chk("bus_be",    {28'b0, bus.bus_be}, {28'b0, r.be});
            chk("bus_wdata", bus.bus_wdata, r.wdata);
            chk("bus_we",    {31'b0, bus.bus_we}, {31'b0, r.we});
          end
        end
        if (stallM) stallCnt++;
        if (prevStall && !stallM) begin
          if (cplQ.size() == 0) begin
            chk("unexpected_cpl", readdataM, 32'hFFFF_FFFF);
          end else begin
            c = cplQ.pop_front();
            chk("readdataM",  readdataM, c.rdata);
            chk("buserrM",    {31'b0, buserrM}, {31'b0, c.err});
            chk("stall_cycles", stallCnt, c.stall);
          end
          stallCnt = 0;
        end
        if (prevErr) chk("buserr_pulse", {31'b0, buserrM}, 32'd0);
        prevReq   = bus.bus_req;
        prevStall = stallM;
        prevErr   = buserrM;
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] size, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input logic noAck,
                        input logic [31:0] eAddr, input logic [3:0] eBe, input logic [31:0] eWdata,
                        input logic [31:0] eRd, input logic eErr, input int eStall);
    req_t r;
    cpl_t c;
    int   cyc;
    r.addr = eAddr; r.be = eBe; r.wdata = eWdata; r.we = we;
    c.rdata = eRd; c.err = eErr; c.stall = eStall;
    reqQ.push_back(r);
    cplQ.push_back(c);
    @(posedge clk); #1;
    memenM = 1'b1; memwriteM = we; memsizeM = size; memsignM = sg;
    aluoutM = a; writedataM = wd;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!noAck && cyc == waits + 1) begin
        bus.bus_ack = 1'b1; bus.bus_rdata = rd;
      end else begin
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h55AA_55AA;
      end
    end while (stallM && cyc < 100);
    if (stallM) chk("stall_release_timeout", {31'b0, stallM}, 32'd0);
    @(posedge clk); #1;
    memenM = 1'b0; bus.bus_ack = 1'b0;
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic misaligned(input logic we, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] keepRd);
    @(posedge clk); #1;
    memenM = 1'b1; memwriteM = we; memsizeM = size; memsignM = 1'b0;
    aluoutM = a; writedataM = 32'h0000_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("adelM",     {31'b0, adelM},  {31'b0, !we});
      chk("adesM",     {31'b0, adesM},  {31'b0, we});
      chk("mis_stall", {31'b0, stallM}, 32'd0);
      chk("mis_req",   {31'b0, bus.bus_req}, 32'd0);
    end
    chk("mis_readdata", readdataM, keepRd);
    @(posedge clk); #1;
    memenM = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    memenM = 1'b0; memwriteM = 1'b0; memsizeM = MEM_WORD; memsignM = 1'b0;
    aluoutM = '0; writedataM = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h55AA_55AA;
    repeat (2) @(negedge clk);
    chk("rst_req",      {31'b0, bus.bus_req}, 32'd0);
    chk("rst_we",       {31'b0, bus.bus_we},  32'd0);
    chk("rst_addr",     bus.bus_addr,  32'd0);
    chk("rst_be",       {28'b0, bus.bus_be}, 32'd0);
    chk("rst_wdata",    bus.bus_wdata, 32'd0);
    chk("rst_readdata", readdataM,     32'd0);
    chk("rst_buserr",   {31'b0, buserrM}, 32'd0);
    chk("rst_stall",    {31'b0, stallM},  32'd0);
    chk("rst_adel",     {31'b0, adelM},   32'd0);
    chk("rst_ades",     {31'b0, adesM},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //     we    size      sg    addr         wdata        rdata        w  na    eAddr        eBe      eWdata       eRd          err  stall
    access(1'b0, MEM_WORD, 1'b0, 32'h0000_0100, 32'h0,      32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 2);
    access(1'b0, MEM_BYTE, 1'b1, 32'h0000_0103, 32'h0,      32'h80FF_0000, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 2);
    access(1'b0, MEM_BYTE, 1'b0, 32'h0000_0103, 32'h0,      32'h80FF_0000, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 2);
    access(1'b1, MEM_HALF, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 1'b0, 5);
    access(1'b0, MEM_HALF, 1'b1, 32'h0000_0102, 32'h0,      32'h8001_7FFF, 1, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 3);
    access(1'b0, MEM_HALF, 1'b0, 32'h0000_0100, 32'h0,      32'h8001_7FFF, 0, 1'b0, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000_7FFF, 1'b0, 2);
    access(1'b1, MEM_BYTE, 1'b0, 32'h0000_0005, 32'h0000_00A5, 32'h0,     0, 1'b0, 32'h0000_0004, 4'b0010, 32'hA5A5_A5A5, 32'h0000_7FFF, 1'b0, 2);
    access(1'b0, MEM_BYTE, 1'b0, 32'h0000_0006, 32'h0,      32'h00C3_0000, 0, 1'b0, 32'h0000_0004, 4'b0100, 32'h0,        32'h0000_00C3, 1'b0, 2);
    access(1'b0, MEM_WORD, 1'b0, 32'h0000_0300, 32'h0,      32'h0,         0, 1'b1, 32'h0000_0300, 4'b1111, 32'h0,        32'h0,         1'b1, TO + 2);

`ifdef DMEM_ALIGN_CHECK_EN
    misaligned(1'b0, MEM_WORD, 32'h0000_0101, 32'h0);
    misaligned(1'b1, MEM_HALF, 32'h0000_0203, 32'h0);
`else
    access(1'b0, MEM_WORD, 1'b0, 32'h0000_0101, 32'h0,      32'h1122_3344, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h1122_3344, 1'b0, 2);
    access(1'b1, MEM_HALF, 1'b0, 32'h0000_0203, 32'h0000_BEEF, 32'h0,     0, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h1122_3344, 1'b0, 2);
`endif

    // Reset while the slave is still pending, then a stray late acknowledge.
    begin
      req_t r;
      r.addr = 32'h0000_0400; r.be = 4'b1111; r.wdata = 32'h0; r.we = 1'b0;
      reqQ.push_back(r);
    end
    @(posedge clk); #1;
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = MEM_WORD; memsignM = 1'b0;
    aluoutM = 32'h0000_0400; writedataM = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; memenM = 1'b0;
    @(negedge clk);
    chk("midrst_req",      {31'b0, bus.bus_req}, 32'd0);
    chk("midrst_stall",    {31'b0, stallM},      32'd0);
    chk("midrst_addr",     bus.bus_addr,         32'd0);
    chk("midrst_readdata", readdataM,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk("lateack_req",      {31'b0, bus.bus_req}, 32'd0);
    chk("lateack_stall",    {31'b0, stallM},      32'd0);
    chk("lateack_readdata", readdataM,            32'd0);
    chk("lateack_buserr",   {31'b0, buserrM},     32'd0);

    access(1'b0, MEM_WORD, 1'b0, 32'h0000_0010, 32'h0,      32'h0123_4567, 0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,        32'h0123_4567, 1'b0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reqQ_drained", reqQ.size(), 32'd0);
    chk("cplQ_drained", cplQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
